pulse_burst_sequencer: RTL
==========================

Name: pulse_burst_sequencer

Overview:
Controller that sequences a pulse-generation datapath. It accepts a burst descriptor (period, high width, pulse count) over a valid/ready handshake, emits a burst of that many periodic pulses, and then reports completion. It sits between a register/config interface and the pulse output pin. It supports a continuous mode and abort, so one pulse resource can be reprogrammed safely between bursts.

Parameters:
CNT_W, 16, width of the period and width counters and fields
BURST_W, 8, width of the pulse-count field and the completed-pulse counter

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
cfg_valid  input  1  descriptor valid
cfg_ready  output  1  sequencer can accept a descriptor
cfg_period  input  CNT_W  pulse period in clk cycles
cfg_width  input  CNT_W  high cycles per period
cfg_count  input  BURST_W  pulses in burst; 0 = continuous until abort
abort  input  1  terminate the running burst
pulse  output  1  registered pulse output
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion strobe
aborted  output  1  qualifies done; held until next accept
cfg_err  output  1  one-cycle strobe on a rejected descriptor
pulses_done  output  BURST_W  completed full periods of current/last burst

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; pulse=0, done=0, cfg_err=0, aborted=0, pulses_done=0, internal phase=0. Reset mid-burst kills the burst immediately, with no done strobe.
- States: IDLE, RUN, DONE. busy = (state!=IDLE).
- cfg_ready = (state==IDLE) && !abort. This is combinational. A descriptor offered while abort=1 is not taken.
- Handshake: a transfer occurs on an edge where cfg_valid && cfg_ready. Fields are latched only on a transfer. cfg_valid may be held high; nothing is consumed outside IDLE.
- Validation at transfer: if cfg_period==0 or cfg_width>cfg_period, the descriptor is rejected. cfg_err=1 for the next cycle, state stays IDLE, and pulses_done and aborted are unchanged.
- Accept edge: state<=RUN, phase<=0, pulses_done<=0, aborted<=0, pulse<=(cfg_width!=0). The first pulse cycle is therefore the cycle right after the accept edge (latency 1).
- RUN, each edge:
  - If abort: pulse<=0, aborted<=1, state<=DONE. Abort has priority over all other RUN actions, and pulses_done is not incremented on that edge.
  - Else if phase==period-1 (period end):
    - phase<=0.
    - pulses_done<=pulses_done+1; this wraps modulo 2^BURST_W in continuous mode.
    - If count!=0 and pulses_done+1==count: pulse<=0, state<=DONE.
    - Else pulse<=(width!=0).
  - Else: phase<=phase+1, pulse<=(phase+1<width).
- Width rules:
  - width==0 gives pulse always 0, but periods are still counted.
  - width==period gives pulse constantly 1 for the whole burst.
  - period==1 with width==1 gives pulse 1 every cycle.
- DONE: done=1 for exactly one cycle, pulse=0, cfg_ready=0. The next edge returns to IDLE; abort in DONE is ignored.
- Timing for a finite burst: done is high in cycle count*period+1 after the accept edge. The burst occupies exactly count*period RUN cycles.
- abort in IDLE is ignored, with no strobe.
- Arithmetic is unsigned. The phase counter is CNT_W bits and never exceeds period-1.

Test Plan:
- Basic burst: period=4, width=1, count=3. Pulse is high in cycles 1, 5 and 9 after accept; done in cycle 13; pulses_done=3; aborted=0.
- Reject: period=0 (and separately width=5, period=4). cfg_err pulses one cycle, cfg_ready stays 1, no pulse, busy=0.
- Continuous and abort: period=3, width=2, count=0. Pattern 110 repeats. Assert abort after 7 cycles in RUN: pulse=0 on the next cycle, done=1 and aborted=1 together, pulses_done=2.
- Edge widths: width=0, period=2, count=2 gives pulse always 0 and done in cycle 5. width=period=3, count=2 gives pulse high for 6 consecutive cycles, then done.
- Back-to-back handshake: hold cfg_valid=1 with two descriptors. The second is accepted only in the first IDLE cycle after done; cfg_ready=0 throughout RUN and DONE. cfg_valid together with abort in IDLE is not accepted.
- Reset mid-burst: drop reset_n during RUN with pulse=1. Pulse goes 0 asynchronously, no done strobe, and after release cfg_ready=1 and pulses_done=0.

Source files
------------

// File: rtl/pulse_burst_sequencer_if.sv
// Descriptor handshake between the config side and the sequencer.
// Master offers a descriptor on cfg_valid; slave takes it when cfg_ready is high.
interface pulse_burst_sequencer_if #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_width;
    logic [BURST_W-1:0] cfg_count;

    modport master (
        output cfg_valid, cfg_period, cfg_width, cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_period, cfg_width, cfg_count,
        output cfg_ready
    );
endinterface

// File: rtl/pulse_burst_sequencer.sv
// Pulse burst sequencer: emits count pulses of a period/width pair; first pulse 1 cycle after accept.
// Backpressure: cfg_ready is low outside IDLE and while abort is high; nothing is consumed then.
module pulse_burst_sequencer #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pulse_burst_sequencer_if.slave cfg,
    input  logic                  abort,
    output logic                  pulse,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  cfg_err,
    output logic [BURST_W-1:0]    pulses_done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [CNT_W-1:0]   period;
        logic [CNT_W-1:0]   width;
        logic [BURST_W-1:0] count;
    } desc_t;

    state_t             state;
    desc_t              desc;
    logic [CNT_W-1:0]   phase;
    logic [CNT_W-1:0]   phase_inc;
    logic [BURST_W-1:0] pd_inc;
    logic               ready;
    logic               take;
    logic               bad_desc;
    logic               period_end;
    logic               last_period;

    assign ready         = (state == IDLE) && !abort;
    assign cfg.cfg_ready = ready;
    assign take          = cfg.cfg_valid && ready;
    assign bad_desc      = (cfg.cfg_period == '0) || (cfg.cfg_width > cfg.cfg_period);
    assign busy          = (state != IDLE);

    assign phase_inc   = phase + CNT_W'(1);
    assign pd_inc      = pulses_done + BURST_W'(1);
    assign period_end  = (phase == desc.period - CNT_W'(1));
    // count==0 means continuous: only abort ends the burst, pulses_done just wraps
    assign last_period = (desc.count != '0) && (pd_inc == desc.count);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            desc        <= '0;
            phase       <= '0;
            pulse       <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            cfg_err     <= 1'b0;
            pulses_done <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        if (bad_desc) begin
                            cfg_err <= 1'b1;
                        end else begin
                            desc        <= {cfg.cfg_period, cfg.cfg_width, cfg.cfg_count};
                            state       <= RUN;
                            phase       <= '0;
                            pulses_done <= '0;
                            aborted     <= 1'b0;
                            pulse       <= (cfg.cfg_width != '0);
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        pulse   <= 1'b0;
                        aborted <= 1'b1;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else if (period_end) begin
                        phase       <= '0;
                        pulses_done <= pd_inc;
                        if (last_period) begin
                            pulse <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            pulse <= (desc.width != '0);
                        end
                    end else begin
                        phase <= phase_inc;
                        pulse <= (phase_inc < desc.width);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
